// File: rtl/lsu.sv
// Load/store unit: takes an effective address from the ALU and runs a req/ack handshake with a
// variable-latency data memory. It aligns store lanes, extends load lanes and pulses completion.
module lsu #(
  parameter int unsigned AWIDTH = 32,
  parameter int unsigned DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              memren_i,
  input  logic              memwren_i,
  input  logic [2:0]        funct3_i,
  input  logic [AWIDTH-1:0] addr_i,
  input  logic [DWIDTH-1:0] store_data_i,
  input  logic [4:0]        rd_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [AWIDTH-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [DWIDTH-1:0] dmem_wdata_o,
  input  logic              dmem_ack_i,
  input  logic [DWIDTH-1:0] dmem_rdata_i,
  output logic              valid_o,
  output logic              wb_en_o,
  output logic [4:0]        rd_o,
  output logic [DWIDTH-1:0] load_data_o,
  output logic              fault_o
);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e      state_q;
  logic        is_load_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;

  logic              accept;
  logic              legal;
  logic [3:0]        be_nxt;
  logic [DWIDTH-1:0] wdata_nxt;
  logic [DWIDTH-1:0] lane;
  logic [DWIDTH-1:0] load_ext;

  assign ready_o = (state_q == StIdle);
  assign accept  = valid_i && (memren_i || memwren_i);

  always_comb begin
    legal     = 1'b0;
    be_nxt    = 4'b0000;
    wdata_nxt = store_data_i;
    // memwren_i wins when both op bits are set, so legality follows the store table.
    if (memwren_i) begin
      legal = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010);
    end else begin
      legal = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
              (funct3_i == 3'b100) || (funct3_i == 3'b101);
    end
    unique case (funct3_i[1:0])
      2'b00: begin
        be_nxt    = 4'b0001 << addr_i[1:0];
        wdata_nxt = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        be_nxt    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_nxt = {2{store_data_i[15:0]}};
        if (addr_i[0]) legal = 1'b0;
      end
      2'b10: begin
        be_nxt = 4'b1111;
        if (addr_i[1:0] != 2'b00) legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    lane     = dmem_rdata_i >> {off_q, 3'b000};
    load_ext = lane;
    unique case (funct3_q)
      3'b000:  load_ext = {{(DWIDTH-8){lane[7]}}, lane[7:0]};
      3'b001:  load_ext = {{(DWIDTH-16){lane[15]}}, lane[15:0]};
      3'b100:  load_ext = {{(DWIDTH-8){1'b0}}, lane[7:0]};
      3'b101:  load_ext = {{(DWIDTH-16){1'b0}}, lane[15:0]};
      default: load_ext = dmem_rdata_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      is_load_q    <= 1'b0;
      funct3_q     <= 3'b000;
      off_q        <= 2'b00;
      rd_q         <= 5'd0;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_be_o    <= 4'b0000;
      dmem_wdata_o <= '0;
      valid_o      <= 1'b0;
      wb_en_o      <= 1'b0;
      fault_o      <= 1'b0;
      rd_o         <= 5'd0;
      load_data_o  <= '0;
    end else begin
      valid_o <= 1'b0;
      wb_en_o <= 1'b0;
      fault_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            is_load_q <= !memwren_i;
            funct3_q  <= funct3_i;
            off_q     <= addr_i[1:0];
            rd_q      <= rd_i;
            if (legal) begin
              state_q      <= StReq;
              dmem_req_o   <= 1'b1;
              dmem_we_o    <= memwren_i;
              dmem_addr_o  <= {addr_i[AWIDTH-1:2], 2'b00};
              dmem_be_o    <= be_nxt;
              dmem_wdata_o <= wdata_nxt;
            end else begin
              // Faults complete without touching memory.
              state_q     <= StResp;
              valid_o     <= 1'b1;
              fault_o     <= 1'b1;
              rd_o        <= rd_i;
              load_data_o <= '0;
            end
          end
        end
        StReq: begin
          if (dmem_ack_i) begin
            state_q     <= StResp;
            dmem_req_o  <= 1'b0;
            valid_o     <= 1'b1;
            wb_en_o     <= is_load_q;
            rd_o        <= rd_q;
            load_data_o <= is_load_q ? load_ext : '0;
          end
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a table of single transactions plus hand-written sequences for
// back-to-back requests, stray acks and reset during an outstanding request.
module tb_lsu;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic        ready_o;
  logic        memren_i;
  logic        memwren_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] store_data_i;
  logic [4:0]  rd_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic        valid_o;
  logic        wb_en_o;
  logic [4:0]  rd_o;
  logic [31:0] load_data_o;
  logic        fault_o;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] Junk = 32'hA5A5_5A5A;

  lsu #(.AWIDTH(32), .DWIDTH(32)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .memren_i(memren_i), .memwren_i(memwren_i), .funct3_i(funct3_i), .addr_i(addr_i),
    .store_data_i(store_data_i), .rd_i(rd_i), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i), .valid_o(valid_o),
    .wb_en_o(wb_en_o), .rd_o(rd_o), .load_data_o(load_data_o), .fault_o(fault_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ren;
    logic        wen;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [4:0]  rd;
    int unsigned wait_c;
    logic [31:0] rdata;
    logic        fault;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] load;
    logic        wb;
  } vec_t;

  vec_t vecs[13];
  vec_t lh_vec;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    chk({tag, ".ready_idle"}, {31'd0, ready_o}, 32'd1);
    valid_i      = 1'b1;
    memren_i     = v.ren;
    memwren_i    = v.wen;
    funct3_i     = v.f3;
    addr_i       = v.addr;
    store_data_i = v.sdata;
    rd_i         = v.rd;
    step();
    valid_i   = 1'b0;
    memren_i  = 1'b0;
    memwren_i = 1'b0;
    if (!v.fault) begin
      for (int w = 0; w <= int'(v.wait_c); w++) begin
        chk({tag, ".req"}, {31'd0, dmem_req_o}, 32'd1);
        chk({tag, ".addr"}, dmem_addr_o, {v.addr[31:2], 2'b00});
        chk({tag, ".be"}, {28'd0, dmem_be_o}, {28'd0, v.be});
        chk({tag, ".we"}, {31'd0, dmem_we_o}, {31'd0, v.wen});
        if (v.wen) chk({tag, ".wdata"}, dmem_wdata_o, v.wdata);
        chk({tag, ".ready_busy"}, {31'd0, ready_o}, 32'd0);
        chk({tag, ".valid_early"}, {31'd0, valid_o}, 32'd0);
        if (w == int'(v.wait_c)) begin
          dmem_ack_i   = 1'b1;
          dmem_rdata_i = v.rdata;
        end
        step();
        dmem_ack_i   = 1'b0;
        dmem_rdata_i = Junk;
      end
    end
    chk({tag, ".req_resp"}, {31'd0, dmem_req_o}, 32'd0);
    chk({tag, ".valid"}, {31'd0, valid_o}, 32'd1);
    chk({tag, ".fault"}, {31'd0, fault_o}, {31'd0, v.fault});
    chk({tag, ".wb_en"}, {31'd0, wb_en_o}, {31'd0, v.wb});
    chk({tag, ".load"}, load_data_o, v.load);
    chk({tag, ".rd"}, {27'd0, rd_o}, {27'd0, v.rd});
    chk({tag, ".ready_resp"}, {31'd0, ready_o}, 32'd0);
    step();
    chk({tag, ".valid_drop"}, {31'd0, valid_o}, 32'd0);
    chk({tag, ".ready_back"}, {31'd0, ready_o}, 32'd1);
  endtask

  initial begin
    // ren wen f3 addr sdata rd wait rdata fault be wdata load wb
    vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h0100_0104, 32'h0, 5'd1, 0, 32'hDEAD_BEEF,
                 1'b0, 4'b1111, 32'h0, 32'hDEAD_BEEF, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h0100_0103, 32'h0, 5'd2, 0, 32'h80FF_0000,
                 1'b0, 4'b1000, 32'h0, 32'hFFFF_FF80, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h0100_0103, 32'h0, 5'd3, 1, 32'h80FF_0000,
                 1'b0, 4'b1000, 32'h0, 32'h0000_0080, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 3'b101, 32'h0100_0102, 32'h0, 5'd4, 0, 32'h80FF_0000,
                 1'b0, 4'b1100, 32'h0, 32'h0000_80FF, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 3'b000, 32'h0100_0101, 32'h1234_5678, 5'd5, 3, 32'h0,
                 1'b0, 4'b0010, 32'h7878_7878, 32'h0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 3'b010, 32'h0100_0102, 32'h0, 5'd6, 0, 32'h0,
                 1'b1, 4'b0000, 32'h0, 32'h0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 3'b011, 32'h0100_0100, 32'h0, 5'd7, 0, 32'h0,
                 1'b1, 4'b0000, 32'h0, 32'h0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 3'b001, 32'h0100_0102, 32'hAABB_CCDD, 5'd8, 1, 32'h0,
                 1'b0, 4'b1100, 32'hCCDD_CCDD, 32'h0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 3'b010, 32'h0100_0108, 32'h1122_3344, 5'd9, 0, 32'h0,
                 1'b0, 4'b1111, 32'h1122_3344, 32'h0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 3'b100, 32'h0100_0100, 32'h1122_3344, 5'd10, 0, 32'h0,
                 1'b1, 4'b0000, 32'h0, 32'h0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 3'b000, 32'h0100_0100, 32'h0000_00A5, 5'd11, 0, 32'hFFFF_FFFF,
                 1'b0, 4'b0001, 32'hA5A5_A5A5, 32'h0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 3'b001, 32'h0100_0103, 32'h0, 5'd12, 0, 32'h0,
                 1'b1, 4'b0000, 32'h0, 32'h0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 3'b000, 32'h0100_0101, 32'h0, 5'd13, 2, 32'h0000_7F00,
                 1'b0, 4'b0010, 32'h0, 32'h0000_007F, 1'b1};
    lh_vec   = '{1'b1, 1'b0, 3'b001, 32'h0100_0100, 32'h0, 5'd14, 0, 32'h0000_8001,
                 1'b0, 4'b0011, 32'h0, 32'hFFFF_8001, 1'b1};

    rst = 1'b0; valid_i = 1'b0; memren_i = 1'b0; memwren_i = 1'b0; funct3_i = 3'b000;
    addr_i = 32'h0; store_data_i = 32'h0; rd_i = 5'd0; dmem_ack_i = 1'b0; dmem_rdata_i = Junk;
    step();
    step();
    chk("reset.ready", {31'd0, ready_o}, 32'd1);
    chk("reset.req", {31'd0, dmem_req_o}, 32'd0);
    chk("reset.valid", {31'd0, valid_o}, 32'd0);
    chk("reset.be", {28'd0, dmem_be_o}, 32'd0);
    chk("reset.load", load_data_o, 32'd0);
    chk("reset.rd", {27'd0, rd_o}, 32'd0);
    rst = 1'b1;
    step();

    for (int i = 0; i < 13; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Stray ack and opless valid in idle must produce nothing.
    dmem_ack_i = 1'b1;
    valid_i    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle.valid", {31'd0, valid_o}, 32'd0);
      chk("idle.req", {31'd0, dmem_req_o}, 32'd0);
      chk("idle.ready", {31'd0, ready_o}, 32'd1);
    end
    dmem_ack_i = 1'b0;

    // Back-to-back: valid_i stays high, second load must wait until after the first's RESP.
    memren_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h0000_0200; rd_i = 5'd3;
    step();
    chk("b2b.req1", {31'd0, dmem_req_o}, 32'd1);
    chk("b2b.addr1", dmem_addr_o, 32'h0000_0200);
    addr_i = 32'h0000_0204; rd_i = 5'd4;
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'h1111_1111;
    step();
    dmem_ack_i = 1'b0; dmem_rdata_i = Junk;
    chk("b2b.valid1", {31'd0, valid_o}, 32'd1);
    chk("b2b.load1", load_data_o, 32'h1111_1111);
    chk("b2b.rd1", {27'd0, rd_o}, 32'd3);
    chk("b2b.ready_resp", {31'd0, ready_o}, 32'd0);
    step();
    chk("b2b.gap_valid", {31'd0, valid_o}, 32'd0);
    chk("b2b.gap_req", {31'd0, dmem_req_o}, 32'd0);
    chk("b2b.gap_ready", {31'd0, ready_o}, 32'd1);
    step();
    valid_i = 1'b0; memren_i = 1'b0;
    chk("b2b.req2", {31'd0, dmem_req_o}, 32'd1);
    chk("b2b.addr2", dmem_addr_o, 32'h0000_0204);
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'h2222_2222;
    step();
    dmem_ack_i = 1'b0; dmem_rdata_i = Junk;
    chk("b2b.valid2", {31'd0, valid_o}, 32'd1);
    chk("b2b.load2", load_data_o, 32'h2222_2222);
    chk("b2b.rd2", {27'd0, rd_o}, 32'd4);
    step();
    chk("b2b.valid_end", {31'd0, valid_o}, 32'd0);

    // Reset while a request is outstanding abandons it.
    valid_i = 1'b1; memren_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h0000_0300; rd_i = 5'd7;
    step();
    valid_i = 1'b0; memren_i = 1'b0;
    chk("rstreq.req_before", {31'd0, dmem_req_o}, 32'd1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("rstreq.req", {31'd0, dmem_req_o}, 32'd0);
    chk("rstreq.ready", {31'd0, ready_o}, 32'd1);
    chk("rstreq.valid", {31'd0, valid_o}, 32'd0);
    step();
    chk("rstreq.valid_after", {31'd0, valid_o}, 32'd0);
    chk("rstreq.req_after", {31'd0, dmem_req_o}, 32'd0);
    run_vec(lh_vec, "lh_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
